// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for a VGA-style display. A horizontal pixel counter
// and a vertical line counter scan the full frame, including blanking. Sync,
// active-video and start-of-blanking flags are decoded from the counters.
//
// Every output comes straight from a flop. The flags are decoded from the
// counters' next-state values, so they line up with x/y on the same cycle.
//
// Ports
//   clk          in   1   pixel clock (single clock domain)
//   rst          in   1   synchronous, active-high reset
//   hsync        out  1   horizontal sync, active low
//   vsync        out  1   vertical sync, active low
//   x            out  10  horizontal position, 0..H_TOTAL-1
//   y            out  10  vertical position, 0..V_TOTAL-1
//   active       out  1   high inside the visible region
//   next_frame   out  1   one-cycle pulse at (0, V_VISIBLE)
//   frame_count  out  8   frames completed, modulo 256
//
// Both totals must be at most 1024 so the counters fit in 10 bits.
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       hsync,
    output logic       vsync,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       next_frame,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // All boundaries as 10-bit constants so every compare is unsigned 10-bit.
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       active_q, active_d;
    logic       next_frame_q, next_frame_d;
    logic [7:0] frame_count_q, frame_count_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        x_d = x_q + 10'd1;
        y_d = y_q;

        if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
        end

        // Flags decoded from the next position so they are registered
        // alongside it and carry no skew relative to x/y.
        hsync_d      = !((x_d >= HS_START) && (x_d < HS_END));
        vsync_d      = !((y_d >= VS_START) && (y_d < VS_END));
        active_d     = (x_d < H_VIS_END) && (y_d < V_VIS_END);
        next_frame_d = (x_d == 10'd0) && (y_d == V_VIS_END);

        // The count advances on the edge that closes the pulse cycle.
        frame_count_d = next_frame_q ? frame_count_q + 8'd1 : frame_count_q;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // Reset parks the raster at the last blanking position so the first
    // released edge naturally lands on (0,0) with all flags consistent.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            active_q      <= 1'b0;
            next_frame_q  <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            next_frame_q  <= next_frame_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign next_frame  = next_frame_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances share one clock and reset:
//   u_dut_def  default 640x480 timing, checked line-level by a vector table
//   u_dut      small raster (16x12 total) so full frames, 257-frame wrap,
//              mid-frame reset and random resets fit in a short run; it is
//              compared every cycle against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    // Small raster used for frame-level behaviour.
    localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 3;
    localparam int S_VV = 6, S_VF = 2, S_VS = 2, S_VB = 2;
    localparam int S_HT = S_HV + S_HF + S_HS + S_HB;   // 16
    localparam int S_VT = S_VV + S_VF + S_VS + S_VB;   // 12
    localparam int S_FRAME = S_HT * S_VT;              // 192
    localparam int S_NF0 = S_VV * S_HT;                // cycle of next_frame

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Default-parameter instance
    logic       d_hsync, d_vsync, d_active, d_nf;
    logic [9:0] d_x, d_y;
    logic [7:0] d_fc;

    vga_timing_gen u_dut_def (
        .clk         (clk),
        .rst         (rst),
        .hsync       (d_hsync),
        .vsync       (d_vsync),
        .x           (d_x),
        .y           (d_y),
        .active      (d_active),
        .next_frame  (d_nf),
        .frame_count (d_fc)
    );

    // Small-raster instance
    logic       s_hsync, s_vsync, s_active, s_nf;
    logic [9:0] s_x, s_y;
    logic [7:0] s_fc;

    vga_timing_gen #(
        .H_VISIBLE (S_HV), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_VISIBLE (S_VV), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .x           (s_x),
        .y           (s_y),
        .active      (s_active),
        .next_frame  (s_nf),
        .frame_count (s_fc)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model for the small raster: position is simply the number
    // of cycles since reset release, split by division into (x,y).
    // Packed as {x, y, hsync, vsync, active, next_frame, frame_count}.
    // ------------------------------------------------------------------
    function automatic logic [31:0] model_out(input bit in_rst, input int t);
        int mx, my, frames;
        logic hs, vs, act, nf;
        if (in_rst)
            return {10'(S_HT - 1), 10'(S_VT - 1), 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        mx  = t % S_HT;
        my  = (t / S_HT) % S_VT;
        hs  = !(mx >= S_HV + S_HF && mx < S_HV + S_HF + S_HS);
        vs  = !(my >= S_VV + S_VF && my < S_VV + S_VF + S_VS);
        act = (mx < S_HV) && (my < S_VV);
        nf  = (mx == 0) && (my == S_VV);
        // Pulses occur at t = k*FRAME + NF0; count those strictly before t.
        frames = (t > S_NF0) ? ((t - S_NF0 - 1) / S_FRAME + 1) : 0;
        return {10'(mx), 10'(my), hs, vs, act, nf, 8'(frames % 256)};
    endfunction

    bit m_valid = 1'b0;   // a reset edge has been seen
    bit m_rst   = 1'b0;   // outputs currently show the reset state
    int m_t     = 0;      // cycles since reset release

    always @(posedge clk) begin
        m_valid <= m_valid | rst;
        m_rst   <= rst;
        m_t     <= (rst || m_rst) ? 0 : m_t + 1;
    end

    always @(negedge clk) begin
        if (m_valid)
            check("model", {s_x, s_y, s_hsync, s_vsync, s_active, s_nf, s_fc},
                  model_out(m_rst, m_t));
    end

    // ------------------------------------------------------------------
    // Vector table for the default instance
    // ------------------------------------------------------------------
    typedef struct {
        logic       rst;    // reset level driven for the step
        int         n;      // clock edges in the step
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       act;
        logic       nf;
        logic [7:0] fc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int vs_low, act_cnt, pulses;
        bit prev_nf, found;

        tbl[0] = '{1'b1,   3, 10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[1] = '{1'b0,   1, 10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
        tbl[2] = '{1'b0, 639, 10'd639, 10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
        tbl[3] = '{1'b0,   1, 10'd640, 10'd0,   1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[4] = '{1'b0,  15, 10'd655, 10'd0,   1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[5] = '{1'b0,   1, 10'd656, 10'd0,   1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[6] = '{1'b0,  95, 10'd751, 10'd0,   1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[7] = '{1'b0,   1, 10'd752, 10'd0,   1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[8] = '{1'b0,  47, 10'd799, 10'd0,   1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[9] = '{1'b0,   1, 10'd0,   10'd1,   1'b1, 1'b1, 1'b1, 1'b0, 8'd0};

        for (int i = 0; i < 10; i++) begin
            rst = tbl[i].rst;
            repeat (tbl[i].n) @(negedge clk);
            check($sformatf("default_vec%0d", i),
                  {d_x, d_y, d_hsync, d_vsync, d_active, d_nf, d_fc},
                  {tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs, tbl[i].act, tbl[i].nf, tbl[i].fc});
        end

        // One full small frame: sync/active totals and return to (0,0).
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vs_low  = 0;
        act_cnt = 0;
        for (int i = 0; i < S_FRAME; i++) begin
            if (!s_vsync) vs_low++;
            if (s_active) act_cnt++;
            @(negedge clk);
        end
        check("frame_vsync_low_cycles", 32'(vs_low), 32'(S_VS * S_HT));
        check("frame_active_cycles", 32'(act_cnt), 32'(S_HV * S_VV));
        check("frame_returns_origin", {22'd0, s_x, s_y}, 32'd0);

        // 257 frames: pulse position and frame_count after each pulse.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulses  = 0;
        prev_nf = 1'b0;
        for (int i = 0; i < 257 * S_FRAME; i++) begin
            if (prev_nf) check("fc_after_pulse", {24'd0, s_fc}, 32'(pulses % 256));
            prev_nf = s_nf;
            if (s_nf) begin
                pulses++;
                check("nf_position", {12'd0, s_x, s_y}, {12'd0, 10'd0, 10'(S_VV)});
            end
            @(negedge clk);
        end
        check("nf_pulse_total", 32'(pulses), 32'd257);
        check("fc_after_257", {24'd0, s_fc}, 32'd1);

        // Mid-frame reset at (5,7).
        found = 1'b0;
        for (int i = 0; i < 2 * S_FRAME && !found; i++) begin
            if (s_x == 10'd5 && s_y == 10'd7) found = 1'b1;
            else @(negedge clk);
        end
        check("reach_5_7", {31'd0, found}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_state", {s_x, s_y, s_hsync, s_vsync, s_active, s_nf, s_fc},
              {10'(S_HT - 1), 10'(S_VT - 1), 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        rst = 1'b0;
        @(negedge clk);
        check("midreset_release", {s_x, s_y, s_hsync, s_vsync, s_active, s_nf, s_fc},
              {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0});

        // Random reset pulses over several frames; the model checks each cycle.
        for (int i = 0; i < 6 * S_FRAME; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
